// File: rtl/decode_pkg.sv
// Shared instruction-field layout and immediate-mode encodings for the decode stage.
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int FIELD_W = 5;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RD_HI = 20;
    localparam int RD_LO = 16;
    localparam int RT_HI = 15;
    localparam int RT_LO = 11;
    localparam int IMM_W = 16;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'b00,   // sign-extended imm16
        IMM_ZEXT = 2'b01,   // zero-extended imm16
        IMM_HI   = 2'b10,   // imm16 placed in the upper half
        IMM_BR   = 2'b11    // sign-extended imm16, word offset (<<2)
    } imm_sel_e;

endpackage

// File: rtl/regfile_bypass.sv
// Register file: synchronous write port, RD_PORTS combinational read ports,
// hard-wired zero register and write-through bypass from the write port.
module regfile_bypass
    import decode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_PORTS = 2
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic [RD_PORTS-1:0][ADDR_W-1:0]    rd_addr,
    output logic [RD_PORTS-1:0][DATA_W-1:0]    rd_data
);

    logic [REG_CNT-1:0][DATA_W-1:0] regs;

    // Storage: reset clears everything; r0 is never written so it stays zero
    always_ff @(posedge Clk) begin
        if (Rst) begin
            regs <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        // Read port: r0 reads zero, a same-cycle write to the address wins
        always_comb begin
            rd_data[p] = '0;
            if (rd_addr[p] != '0) begin
                if (wr_en && (wr_addr == rd_addr[p])) begin
                    rd_data[p] = wr_data;
                end else begin
                    rd_data[p] = regs[rd_addr[p]];
                end
            end
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Pipelined decode stage: RF read with bypass, immediate generation,
// load-use hazard detection and the registered ID/EX boundary.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [INSTR_W-1:0]  Instr,
    input  logic                In_valid,
    input  logic                Is_load,
    input  logic                RF_B_sel,
    input  logic                Uses_B,
    input  logic [1:0]          Immed_sel,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                WB_WrEn,
    input  logic [ADDR_W-1:0]   WB_Addr,
    input  logic [DATA_W-1:0]   WB_Data,
    output logic                Hazard,
    output logic                Out_valid,
    output logic                Out_load,
    output logic [ADDR_W-1:0]   Out_rd,
    output logic [ADDR_W-1:0]   Out_ra,
    output logic [ADDR_W-1:0]   Out_rb,
    output logic [DATA_W-1:0]   RF_A,
    output logic [DATA_W-1:0]   RF_B,
    output logic [DATA_W-1:0]   Immed
);

    // Immediates are built at least 32 bits wide, then cut to DATA_W
    localparam int EXT_W  = (DATA_W > INSTR_W) ? DATA_W : INSTR_W;
    localparam int STAGES = 1;

    logic [FIELD_W-1:0]          rs_f, rd_f, rt_f;
    logic [ADDR_W-1:0]           rs_a, rd_a, rb_a;
    logic [IMM_W-1:0]            imm16;
    logic [EXT_W-1:0]            imm_sext, imm_zext, imm_ext;
    logic [1:0][ADDR_W-1:0]      rf_addr;
    logic [1:0][DATA_W-1:0]      rf_data;
    logic [STAGES:0]             vld_pipe;
    logic                        unused_bits;

    assign rs_f  = Instr[RS_HI:RS_LO];
    assign rd_f  = Instr[RD_HI:RD_LO];
    assign rt_f  = Instr[RT_HI:RT_LO];
    assign imm16 = Instr[IMM_W-1:0];

    // Narrow register files use only the low bits of each 5-bit field
    assign rs_a = rs_f[ADDR_W-1:0];
    assign rd_a = rd_f[ADDR_W-1:0];
    assign rb_a = RF_B_sel ? rd_f[ADDR_W-1:0] : rt_f[ADDR_W-1:0];

    assign rf_addr[0] = rs_a;
    assign rf_addr[1] = rb_a;

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .REG_CNT  (REG_CNT),
        .ADDR_W   (ADDR_W),
        .RD_PORTS (2)
    ) u_rf (
        .Clk     (Clk),
        .Rst     (Rst),
        .wr_en   (WB_WrEn),
        .wr_addr (WB_Addr),
        .wr_data (WB_Data),
        .rd_addr (rf_addr),
        .rd_data (rf_data)
    );

    assign imm_sext = {{(EXT_W-IMM_W){imm16[IMM_W-1]}}, imm16};
    assign imm_zext = {{(EXT_W-IMM_W){1'b0}}, imm16};

    // Immediate mode select; HI is zero-filled above, BR keeps the sign
    always_comb begin
        imm_ext = imm_sext;
        unique case (imm_sel_e'(Immed_sel))
            IMM_SEXT: imm_ext = imm_sext;
            IMM_ZEXT: imm_ext = imm_zext;
            IMM_HI:   imm_ext = imm_zext << IMM_W;
            IMM_BR:   imm_ext = imm_sext << 2;
            default:  imm_ext = imm_sext;
        endcase
    end

    // Load in ID/EX whose destination feeds this instruction: hold upstream.
    // Evaluated against whatever ID/EX holds, including during a stall.
    assign Hazard = In_valid & Out_valid & Out_load & (Out_rd != '0) &
                    ((Out_rd == rs_a) | (Uses_B & (Out_rd == rb_a)));

    assign vld_pipe[0] = In_valid;
    assign Out_valid   = vld_pipe[STAGES];

    // ID/EX register: reset > flush > stall(hold) > hazard bubble > load
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_pipe[STAGES] <= 1'b0;
            Out_load         <= 1'b0;
            Out_rd           <= '0;
            Out_ra           <= '0;
            Out_rb           <= '0;
            RF_A             <= '0;
            RF_B             <= '0;
            Immed            <= '0;
        end else if (Flush) begin
            vld_pipe[STAGES] <= 1'b0;
        end else if (!Stall) begin
            if (Hazard) begin
                vld_pipe[STAGES] <= 1'b0;
                Out_load         <= 1'b0;
            end else begin
                vld_pipe[STAGES] <= vld_pipe[0];
                Out_load         <= Is_load & In_valid;
                Out_rd           <= rd_a;
                Out_ra           <= rs_a;
                Out_rb           <= rb_a;
                RF_A             <= rf_data[0];
                RF_B             <= rf_data[1];
                Immed            <= imm_ext[DATA_W-1:0];
            end
        end
    end

    // Opcode, high field bits of narrow configs and truncated immediate bits
    assign unused_bits = ^{Instr[OP_HI:OP_LO], rs_f, rd_f, rt_f, imm_ext};

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised, pipelined successor of the single-cycle decode stage.
- Decodes the instruction: register-file read with port-B address select, immediate generation in four modes, write-through bypass from writeback, load-use hazard detection.
- Results land in a registered ID/EX boundary with valid, stall and flush control.
- Sits between the fetch/IF-ID register and the execute stage of the pipelined datapath.

Parameters:
- DATA_W, 32, width of registers, operands and immediate.
- REG_CNT, 32, number of architectural registers; register 0 reads as zero.
- ADDR_W, 5, register address width; must equal clog2(REG_CNT) and must be ≤5.

Ports:
- Clk  in  1  single clock, all state updates on rising edge.
- Rst  in  1  synchronous reset, active-high.
- Instr  in  32  instruction: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], imm[15:0].
- In_valid  in  1  Instr is a real instruction.
- Is_load  in  1  Instr is a load; used for hazard tracking.
- RF_B_sel  in  1  0: port-B address = Instr[15:11]; 1: Instr[20:16].
- Uses_B  in  1  current instruction reads port B; gates hazard compare.
- Immed_sel  in  2  00 sign-ext imm16; 01 zero-ext imm16; 10 imm16<<16; 11 sign-ext imm16<<2.
- Stall  in  1  downstream stall; ID/EX register holds.
- Flush  in  1  kill contents of ID/EX register.
- WB_WrEn  in  1  writeback write enable.
- WB_Addr  in  ADDR_W  writeback register address.
- WB_Data  in  DATA_W  writeback data.
- Hazard  out  1  combinational load-use hazard; upstream must hold IF-ID and PC.
- Out_valid  out  1  ID/EX register holds a valid instruction.
- Out_load  out  1  registered Is_load.
- Out_rd  out  ADDR_W  registered Instr[20:16].
- Out_ra  out  ADDR_W  registered port-A address, for forwarding.
- Out_rb  out  ADDR_W  registered selected port-B address.
- RF_A  out  DATA_W  registered operand A.
- RF_B  out  DATA_W  registered operand B.
- Immed  out  DATA_W  registered immediate.

Behaviour:
- Reset: every RF entry = 0; Out_valid = 0, Out_load = 0; all address and data outputs = 0. Takes effect on the first rising edge with Rst = 1. Mid-operation reset discards the ID/EX contents and the same-edge RF write.
- RF write: on a rising edge when WB_WrEn = 1 and WB_Addr ≠ 0, entry WB_Addr ← WB_Data. Writes to register 0 are ignored. Writes proceed regardless of Stall, Flush or Hazard.
- RF read: combinational. Read address 0 → 0.
- Bypass: if WB_WrEn = 1 and WB_Addr equals a nonzero read address, the read returns WB_Data in the same cycle.
- Immediates: widths of 32 bits and above are filled per mode. For DATA_W < 32, the result is truncated to the low DATA_W bits.
- Hazard = In_valid & Out_valid & Out_load & (Out_rd ≠ 0) & ((Out_rd == rs) | (Uses_B & Out_rd == selected B addr)).
- ID/EX update priority on each edge:
  - Rst: reset values.
  - Flush: Out_valid ← 0; other fields don't-care, implemented as hold.
  - Stall: all fields hold, including Out_valid. Hazard stays evaluated against the held contents.
  - Hazard: bubble; Out_valid ← 0, Out_load ← 0.
  - Otherwise: load all fields; Out_valid ← In_valid, Out_load ← Is_load & In_valid.
- Latency: one cycle, Instr to outputs.
- Stall and Flush both high: Flush wins.
- Operands held during Stall are not refreshed by later writebacks; execute-stage forwarding covers this, using Out_ra and Out_rb.

Decomposition:
- Shared package decode_pkg:
  - field offsets (OP_HI/LO, RS_HI/LO, RD_HI/LO, RT_HI/LO, IMM_W = 16);
  - Immed_sel encodings IMM_SEXT, IMM_ZEXT, IMM_HI, IMM_BR.
- One sub-module, regfile_bypass: parametrised RF with two read ports, one write port, zero-register and write-through bypass.
- decode_pipe instantiates regfile_bypass and holds the immediate logic, hazard logic and ID/EX register.

Test Plan:
- Reset then read: Rst = 1 for 2 cycles, then Instr rs = 3, rt = 4 → RF_A = 0, RF_B = 0, Out_valid = 0 during reset, 1 one cycle after In_valid.
- Write/bypass: WB_WrEn = 1, WB_Addr = 5, WB_Data = 0xDEADBEEF in the same cycle as Instr rs = 5 → RF_A = 0xDEADBEEF on the next edge. A write to r0 with 0x1234 → r0 still reads 0.
- Immediates with imm16 = 0x8004:
  - Immed_sel 00 → 0xFFFF8004;
  - 01 → 0x00008004;
  - 10 → 0x80040000;
  - 11 → 0xFFFE0010.
- Load-use: load with rd = 7 in ID/EX, next Instr rs = 7 → Hazard = 1, next edge Out_valid = 0. With Uses_B = 0 and only rt = 7 → Hazard = 0.
- Stall/Flush: Stall = 1 for 3 cycles → all outputs constant. Stall = 1 and Flush = 1 → Out_valid = 0 next edge.
- Parametrisation: DATA_W = 16, REG_CNT = 8, ADDR_W = 3 → write 0xABCD to r7, read back 0xABCD; Immed_sel 00 with imm16 = 0x8004 → 0x8004.
